// File: rtl/uart_frame_pkg.sv
// rtl/uart_frame_pkg.sv - shared states and constants for the UART packet framer
package uart_frame_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SOF,
    ST_LEN,
    ST_PAY,
    ST_CHK
  } frame_state_e;

  typedef enum logic [1:0] {
    SUB_ISSUE,
    SUB_ACK,
    SUB_DRAIN
  } byte_phase_e;

  localparam logic [7:0] SOF_BYTE_DEFAULT = 8'h7E;

endpackage

// File: rtl/uart_sync_fifo.sv
// rtl/uart_sync_fifo.sv - first-word-fall-through synchronous FIFO with full/empty/count
module uart_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_en_i,
  input  logic [WIDTH-1:0] wr_data_i,
  input  logic             rd_en_i,
  output logic [WIDTH-1:0] rd_data_o,
  output logic             full_o,
  output logic             empty_o,
  output logic [AW:0]      count_o
);

  localparam logic [AW:0] DEPTH_CNT = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q;
  logic [AW-1:0]    rd_ptr_q;
  logic [AW:0]      count_q;
  logic             push;
  logic             pop;

  assign push      = wr_en_i && !full_o;
  assign pop       = rd_en_i && !empty_o;
  assign full_o    = (count_q == DEPTH_CNT);
  assign empty_o   = (count_q == '0);
  assign count_o   = count_q;
  assign rd_data_o = mem_q[rd_ptr_q];

  // Pointer and occupancy tracking; a simultaneous push and pop leaves the count unchanged.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      if (push && !pop)      count_q <= count_q + 1'b1;
      else if (pop && !push) count_q <= count_q - 1'b1;
    end
  end

  // Storage array; contents need no reset because the pointers define validity.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= wr_data_i;
  end

endmodule

// File: rtl/uart_tx_framer.sv
// rtl/uart_tx_framer.sv - buffers payload and frames it as SOF, LEN, payload, CHK to a UART host
module uart_tx_framer
  import uart_frame_pkg::*;
#(
  parameter int DATA_BITS  = 8,
  parameter int FIFO_DEPTH = 16,
  parameter int LEN_DEPTH  = 4,
  parameter int MAX_LEN    = 16,
  parameter logic [DATA_BITS-1:0] SOF_BYTE = DATA_BITS'(SOF_BYTE_DEFAULT)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [DATA_BITS-1:0] in_data,
  input  logic                 in_valid,
  input  logic                 in_last,
  output logic                 in_ready,
  output logic [DATA_BITS-1:0] tx_data,
  output logic                 tx_start,
  input  logic                 tx_busy,
  output logic                 frame_done,
  output logic                 trunc_err,
  output logic                 framer_busy
);

  logic [DATA_BITS-1:0] wr_cnt_q;
  logic [DATA_BITS-1:0] cnt_plus;
  logic                 push;
  logic                 at_max;
  logic                 len_push;
  logic                 trunc_q;

  logic                 data_full, data_empty, data_pop;
  logic [DATA_BITS-1:0] data_head;
  logic [$clog2(FIFO_DEPTH):0] data_count;
  logic                 len_full, len_empty, len_pop;
  logic [DATA_BITS-1:0] len_head;
  logic [$clog2(LEN_DEPTH):0] len_count;
  logic                 unused_fifo_status;

  frame_state_e         state_q, state_d;
  byte_phase_e          sub_q, sub_d;
  logic [DATA_BITS-1:0] len_q, len_d;
  logic [DATA_BITS-1:0] pay_cnt_q, pay_cnt_d;
  logic [DATA_BITS-1:0] chk_q, chk_d;
  logic [DATA_BITS-1:0] tx_data_q, tx_data_d;
  logic                 frame_done_q, frame_done_d;

  assign in_ready  = !data_full && !len_full;
  assign push      = in_valid && in_ready;
  assign cnt_plus  = wr_cnt_q + 1'b1;
  assign at_max    = (cnt_plus == DATA_BITS'(MAX_LEN));
  assign len_push  = push && (in_last || at_max);
  assign unused_fifo_status = ^{data_empty, data_count, len_count};

  uart_sync_fifo #(.WIDTH(DATA_BITS), .DEPTH(FIFO_DEPTH)) u_data_fifo (
    .clk       (clk),
    .rst       (rst),
    .wr_en_i   (push),
    .wr_data_i (in_data),
    .rd_en_i   (data_pop),
    .rd_data_o (data_head),
    .full_o    (data_full),
    .empty_o   (data_empty),
    .count_o   (data_count)
  );

  uart_sync_fifo #(.WIDTH(DATA_BITS), .DEPTH(LEN_DEPTH)) u_len_fifo (
    .clk       (clk),
    .rst       (rst),
    .wr_en_i   (len_push),
    .wr_data_i (cnt_plus),
    .rd_en_i   (len_pop),
    .rd_data_o (len_head),
    .full_o    (len_full),
    .empty_o   (len_empty),
    .count_o   (len_count)
  );

  // Packet length counter; closes a packet on in_last or forcibly at MAX_LEN.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_cnt_q <= '0;
      trunc_q  <= 1'b0;
    end else begin
      trunc_q <= push && at_max && !in_last;
      if (len_push)  wr_cnt_q <= '0;
      else if (push) wr_cnt_q <= cnt_plus;
    end
  end

  // Frame state, byte phase and datapath registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      sub_q        <= SUB_ISSUE;
      len_q        <= '0;
      pay_cnt_q    <= '0;
      chk_q        <= '0;
      tx_data_q    <= '0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      sub_q        <= sub_d;
      len_q        <= len_d;
      pay_cnt_q    <= pay_cnt_d;
      chk_q        <= chk_d;
      tx_data_q    <= tx_data_d;
      frame_done_q <= frame_done_d;
    end
  end

  // Next byte is loaded into tx_data on entry to ISSUE so it is stable through ACK.
  always_comb begin
    state_d      = state_q;
    sub_d        = sub_q;
    len_d        = len_q;
    pay_cnt_d    = pay_cnt_q;
    chk_d        = chk_q;
    tx_data_d    = tx_data_q;
    frame_done_d = 1'b0;
    len_pop      = 1'b0;
    data_pop     = 1'b0;
    if (state_q == ST_IDLE) begin
      if (!len_empty && !tx_busy) begin
        len_pop   = 1'b1;
        len_d     = len_head;
        chk_d     = '0;
        pay_cnt_d = '0;
        state_d   = ST_SOF;
        sub_d     = SUB_ISSUE;
        tx_data_d = SOF_BYTE;
      end
    end else begin
      unique case (sub_q)
        SUB_ISSUE: sub_d = SUB_ACK;
        SUB_ACK: if (tx_busy) sub_d = SUB_DRAIN;
        SUB_DRAIN: begin
          if (!tx_busy) begin
            sub_d = SUB_ISSUE;
            unique case (state_q)
              ST_SOF: begin
                state_d   = ST_LEN;
                tx_data_d = len_q;
                chk_d     = len_q;
              end
              ST_LEN, ST_PAY: begin
                if (pay_cnt_q == len_q) begin
                  state_d   = ST_CHK;
                  tx_data_d = chk_q;
                end else begin
                  state_d   = ST_PAY;
                  data_pop  = 1'b1;
                  tx_data_d = data_head;
                  chk_d     = chk_q ^ data_head;
                  pay_cnt_d = pay_cnt_q + 1'b1;
                end
              end
              ST_CHK: begin
                state_d      = ST_IDLE;
                frame_done_d = 1'b1;
              end
              default: state_d = ST_IDLE;
            endcase
          end
        end
        default: sub_d = SUB_ISSUE;
      endcase
    end
  end

  assign tx_start    = (state_q != ST_IDLE) && (sub_q == SUB_ISSUE);
  assign tx_data     = tx_data_q;
  assign frame_done  = frame_done_q;
  assign trunc_err   = trunc_q;
  assign framer_busy = (state_q != ST_IDLE);

endmodule

// File: tb/tb_uart_tx_framer.sv
// tb/tb_uart_tx_framer.sv - directed self-checking bench for uart_tx_framer
module tb_uart_tx_framer;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] in_data = 8'h00;
  logic       in_valid = 1'b0;
  logic       in_last = 1'b0;
  logic       in_ready;
  logic [7:0] tx_data;
  logic       tx_start;
  logic       tx_busy;
  logic       frame_done;
  logic       trunc_err;
  logic       framer_busy;

  int checks = 0;
  int errors = 0;

  logic hold_busy = 1'b0;
  int   busy_len = 20;
  int   busy_cnt;

  logic [7:0] cap_q[$];
  logic [7:0] exp_q[$];
  int   start_cnt = 0;
  int   fd_cnt = 0;
  int   tr_cnt = 0;
  int   stab_viol = 0;
  int   start_busy_viol = 0;
  int   gap_viol = 0;
  int   gap_cnt = 0;
  logic wait_rise = 1'b0;
  logic [7:0] held = 8'h00;

  uart_tx_framer dut (
    .clk         (clk),
    .rst         (rst),
    .in_data     (in_data),
    .in_valid    (in_valid),
    .in_last     (in_last),
    .in_ready    (in_ready),
    .tx_data     (tx_data),
    .tx_start    (tx_start),
    .tx_busy     (tx_busy),
    .frame_done  (frame_done),
    .trunc_err   (trunc_err),
    .framer_busy (framer_busy)
  );

  always #5 clk = ~clk;

  assign tx_busy = hold_busy || (busy_cnt != 0);

  always @(posedge clk or posedge rst) begin
    if (rst) busy_cnt <= 0;
    else if (tx_start) busy_cnt <= busy_len;
    else if (busy_cnt > 0) busy_cnt <= busy_cnt - 1;
  end

  always @(negedge clk) begin
    if (rst) begin
      wait_rise <= 1'b0;
      gap_cnt   <= 0;
    end else begin
      if (tx_start) begin
        cap_q.push_back(tx_data);
        start_cnt <= start_cnt + 1;
        if (tx_busy) start_busy_viol <= start_busy_viol + 1;
        if (gap_cnt > 1) gap_viol <= gap_viol + 1;
        gap_cnt   <= 0;
        held      <= tx_data;
        wait_rise <= 1'b1;
      end else begin
        if (wait_rise) begin
          if (tx_busy) wait_rise <= 1'b0;
          else if (tx_data !== held) stab_viol <= stab_viol + 1;
        end
        if (frame_done) gap_cnt <= 0;
        else if (framer_busy && !tx_busy) gap_cnt <= gap_cnt + 1;
      end
      if (frame_done) fd_cnt <= fd_cnt + 1;
      if (trunc_err) tr_cnt <= tr_cnt + 1;
    end
  end

  task automatic push(input logic [7:0] d, input logic l);
    int k = 0;
    in_data  = d;
    in_last  = l;
    in_valid = 1'b1;
    while (!in_ready && k < 5000) begin
      @(negedge clk);
      k++;
    end
    checks++;
    if (k >= 5000) begin
      errors++;
      $display("FAIL push_stall in_ready stayed %0b for byte %02h, want 1", in_ready, d);
    end
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic wait_frames(input int n);
    int s0 = fd_cnt;
    int k = 0;
    while (fd_cnt < s0 + n && k < 20000) begin
      @(negedge clk);
      k++;
    end
    checks++;
    if (k >= 20000) begin
      errors++;
      $display("FAIL frame_timeout got %0d frames want %0d", fd_cnt - s0, n);
    end
    repeat (3) @(negedge clk);
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    checks++;
    if ({tx_start, tx_data, frame_done, trunc_err, framer_busy} !== 12'h000) begin
      errors++;
      $display("FAIL reset_outputs got start=%0b data=%02h fd=%0b tr=%0b busy=%0b want all 0",
               tx_start, tx_data, frame_done, trunc_err, framer_busy);
    end
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_in_ready got %0b want 1", in_ready);
    end
  endtask

  task automatic test_single();
    int fd0 = fd_cnt;
    int tr0 = tr_cnt;
    cap_q.delete();
    exp_q = '{8'h7E, 8'h03, 8'h01, 8'h02, 8'h03, 8'h03};
    push(8'h01, 1'b0);
    push(8'h02, 1'b0);
    push(8'h03, 1'b1);
    checks++;
    if (tx_start !== 1'b0) begin
      errors++;
      $display("FAIL single_early_start got %0b want 0", tx_start);
    end
    @(negedge clk);
    checks++;
    if (tx_start !== 1'b1 || framer_busy !== 1'b1 || tx_data !== 8'h7E) begin
      errors++;
      $display("FAIL single_sof_latency got start=%0b busy=%0b data=%02h want 1 1 7e",
               tx_start, framer_busy, tx_data);
    end
    wait_frames(1);
    checks++;
    if (cap_q.size() != exp_q.size()) begin
      errors++;
      $display("FAIL single_count got %0d want %0d", cap_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size(); i++) begin
      checks++;
      if (i >= cap_q.size() || cap_q[i] !== exp_q[i]) begin
        errors++;
        $display("FAIL single_byte%0d got %02h want %02h", i, (i < cap_q.size()) ? cap_q[i] : 8'hxx, exp_q[i]);
      end
    end
    checks++;
    if (fd_cnt - fd0 != 1 || tr_cnt != tr0) begin
      errors++;
      $display("FAIL single_pulses got fd=%0d tr=%0d want fd=1 tr=0", fd_cnt - fd0, tr_cnt - tr0);
    end
  endtask

  task automatic test_truncation();
    int tr0 = tr_cnt;
    cap_q.delete();
    exp_q = '{8'h7E, 8'h10};
    for (int i = 0; i < 16; i++) exp_q.push_back(8'h10 + 8'(i));
    exp_q.push_back(8'h10);
    exp_q.push_back(8'h7E);
    exp_q.push_back(8'h01);
    exp_q.push_back(8'h20);
    exp_q.push_back(8'h21);
    for (int i = 0; i < 17; i++) push(8'h10 + 8'(i), i == 16);
    wait_frames(2);
    checks++;
    if (cap_q.size() != exp_q.size()) begin
      errors++;
      $display("FAIL trunc_count got %0d want %0d", cap_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size(); i++) begin
      checks++;
      if (i >= cap_q.size() || cap_q[i] !== exp_q[i]) begin
        errors++;
        $display("FAIL trunc_byte%0d got %02h want %02h", i, (i < cap_q.size()) ? cap_q[i] : 8'hxx, exp_q[i]);
      end
    end
    checks++;
    if (tr_cnt - tr0 != 1) begin
      errors++;
      $display("FAIL trunc_pulse got %0d cycles want 1", tr_cnt - tr0);
    end
  endtask

  task automatic test_backpressure();
    logic [7:0] x;
    cap_q.delete();
    exp_q.delete();
    hold_busy = 1'b1;
    for (int k = 0; k < 4; k++) begin
      push(8'h30 + 8'(k), 1'b0);
      push(8'h40 + 8'(k), 1'b1);
      x = 8'h02 ^ (8'h30 + 8'(k)) ^ (8'h40 + 8'(k));
      exp_q.push_back(8'h7E);
      exp_q.push_back(8'h02);
      exp_q.push_back(8'h30 + 8'(k));
      exp_q.push_back(8'h40 + 8'(k));
      exp_q.push_back(x);
    end
    checks++;
    if (in_ready !== 1'b0) begin
      errors++;
      $display("FAIL bp_len_full in_ready got %0b want 0", in_ready);
    end
    hold_busy = 1'b0;
    wait_frames(4);
    hold_busy = 1'b1;
    for (int i = 0; i < 16; i++) begin
      push(8'h80 + 8'(i), (i == 7) || (i == 15));
      if (i < 15) begin
        checks++;
        if (in_ready !== 1'b1) begin
          errors++;
          $display("FAIL bp_early_drop after byte %0d in_ready got %0b want 1", i, in_ready);
        end
      end
    end
    checks++;
    if (in_ready !== 1'b0) begin
      errors++;
      $display("FAIL bp_data_full in_ready got %0b want 0", in_ready);
    end
    for (int p = 0; p < 2; p++) begin
      exp_q.push_back(8'h7E);
      exp_q.push_back(8'h08);
      for (int i = 0; i < 8; i++) exp_q.push_back(8'h80 + 8'(p * 8 + i));
      exp_q.push_back(8'h08);
    end
    hold_busy = 1'b0;
    wait_frames(2);
    checks++;
    if (cap_q.size() != exp_q.size()) begin
      errors++;
      $display("FAIL bp_count got %0d want %0d", cap_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size(); i++) begin
      checks++;
      if (i >= cap_q.size() || cap_q[i] !== exp_q[i]) begin
        errors++;
        $display("FAIL bp_byte%0d got %02h want %02h", i, (i < cap_q.size()) ? cap_q[i] : 8'hxx, exp_q[i]);
      end
    end
  endtask

  task automatic test_pacing();
    int s0 = start_cnt;
    int sv0 = stab_viol;
    int bv0 = start_busy_viol;
    int gv0 = gap_viol;
    cap_q.delete();
    exp_q = '{8'h7E, 8'h02, 8'h5A, 8'hC3, 8'h9B};
    busy_len = 100;
    push(8'h5A, 1'b0);
    push(8'hC3, 1'b1);
    wait_frames(1);
    busy_len = 20;
    checks++;
    if (start_cnt - s0 != 5) begin
      errors++;
      $display("FAIL pace_starts got %0d want 5", start_cnt - s0);
    end
    for (int i = 0; i < exp_q.size(); i++) begin
      checks++;
      if (i >= cap_q.size() || cap_q[i] !== exp_q[i]) begin
        errors++;
        $display("FAIL pace_byte%0d got %02h want %02h", i, (i < cap_q.size()) ? cap_q[i] : 8'hxx, exp_q[i]);
      end
    end
    checks++;
    if (stab_viol != sv0 || start_busy_viol != bv0 || gap_viol != gv0) begin
      errors++;
      $display("FAIL pace_handshake got unstable=%0d start_while_busy=%0d late_start=%0d want 0 0 0",
               stab_viol - sv0, start_busy_viol - bv0, gap_viol - gv0);
    end
  endtask

  task automatic test_reset_mid();
    int s0 = start_cnt;
    int k = 0;
    for (int i = 0; i < 5; i++) push(8'h11 + 8'(i), i == 4);
    while (start_cnt < s0 + 3 && k < 5000) begin
      @(negedge clk);
      k++;
    end
    repeat (5) @(negedge clk);
    checks++;
    if (framer_busy !== 1'b1) begin
      errors++;
      $display("FAIL mid_in_frame framer_busy got %0b want 1", framer_busy);
    end
    rst = 1'b1;
    #1;
    checks++;
    if ({tx_start, tx_data, frame_done, trunc_err, framer_busy} !== 12'h000) begin
      errors++;
      $display("FAIL mid_reset_outputs got start=%0b data=%02h fd=%0b tr=%0b busy=%0b want all 0",
               tx_start, tx_data, frame_done, trunc_err, framer_busy);
    end
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b1 || framer_busy !== 1'b0) begin
      errors++;
      $display("FAIL mid_release got in_ready=%0b busy=%0b want 1 0", in_ready, framer_busy);
    end
    cap_q.delete();
    exp_q = '{8'h7E, 8'h01, 8'hAA, 8'hAB};
    push(8'hAA, 1'b1);
    wait_frames(1);
    checks++;
    if (cap_q.size() != exp_q.size()) begin
      errors++;
      $display("FAIL mid_count got %0d want %0d", cap_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size(); i++) begin
      checks++;
      if (i >= cap_q.size() || cap_q[i] !== exp_q[i]) begin
        errors++;
        $display("FAIL mid_byte%0d got %02h want %02h", i, (i < cap_q.size()) ? cap_q[i] : 8'hxx, exp_q[i]);
      end
    end
  endtask

  task automatic test_back_to_back();
    int fd0 = fd_cnt;
    cap_q.delete();
    exp_q = '{8'h7E, 8'h01, 8'h55, 8'h54, 8'h7E, 8'h01, 8'h66, 8'h67};
    push(8'h55, 1'b1);
    push(8'h66, 1'b1);
    wait_frames(2);
    checks++;
    if (cap_q.size() != exp_q.size()) begin
      errors++;
      $display("FAIL b2b_count got %0d want %0d", cap_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size(); i++) begin
      checks++;
      if (i >= cap_q.size() || cap_q[i] !== exp_q[i]) begin
        errors++;
        $display("FAIL b2b_byte%0d got %02h want %02h", i, (i < cap_q.size()) ? cap_q[i] : 8'hxx, exp_q[i]);
      end
    end
    checks++;
    if (fd_cnt - fd0 != 2) begin
      errors++;
      $display("FAIL b2b_frame_done got %0d want 2", fd_cnt - fd0);
    end
    checks++;
    if (stab_viol != 0 || start_busy_viol != 0 || gap_viol != 0) begin
      errors++;
      $display("FAIL global_handshake got unstable=%0d start_while_busy=%0d late_start=%0d want 0 0 0",
               stab_viol, start_busy_viol, gap_viol);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_truncation();
    test_backpressure();
    test_pacing();
    test_reset_mid();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
